turn_signal_ctrl: RTL
=====================

// Module: turn_signal_ctrl
// PURPOSE
//  Upstream stage of the car-light flasher. Conditions the three raw driver
//  buttons (left, right, hazard) and runs the turn-signal mode FSM. Drives the
//  en_l/en_r level enables that the LED flasher consumes (both high = hazard).
//  Left/right modes auto-cancel after a timeout; hazard mode does not.
// PARAMETERS
//  DB_CYCLES       240000      stable-input cycles for a debounced edge (20 ms @ 12 MHz)
//  TIMEOUT_CYCLES  360000000   left/right auto-cancel time in cycles (30 s @ 12 MHz)
// PORTS
//  clk          in   1  system clock, 12 MHz board oscillator
//  rst          in   1  asynchronous, active-high reset
//  btn_l        in   1  raw left button, high = pressed, asynchronous to clk
//  btn_r        in   1  raw right button, high = pressed, asynchronous to clk
//  btn_haz      in   1  raw hazard button, high = pressed, asynchronous to clk
//  en_l         out  1  left-side enable to flasher, registered
//  en_r         out  1  right-side enable to flasher, registered
//  mode         out  2  current FSM state: 0 IDLE, 1 LEFT, 2 RIGHT, 3 HAZARD
//  timeout_evt  out  1  one-cycle pulse when LEFT/RIGHT auto-cancels
// BEHAVIOUR
//  Reset: mode=IDLE, en_l=0, en_r=0, timeout_evt=0. All sync flops, debounce
//   levels and counters clear to 0 on rst, even mid-operation.
//  Conditioning, per button: 2-flop synchroniser, then debouncer. The debounced
//   level toggles when the synced input has differed from it for DB_CYCLES
//   consecutive cycles. A disagreement shorter than that reloads the counter.
//   press = one-cycle pulse on a debounced 0->1. Releases generate no event.
//  Latency: a raw press held steady moves mode exactly DB_CYCLES+4 cycles after
//   the input rises. That is 2 sync, DB_CYCLES count, 1 edge reg and 1 state reg.
//  Events, evaluated per cycle with this priority:
//   1 press_haz: HAZARD -> IDLE, any other state -> HAZARD.
//   2 press_l and press_r in the same cycle (no haz): ignored, state held.
//   3 press_l: LEFT -> IDLE, IDLE/RIGHT -> LEFT, HAZARD -> held (ignored).
//   4 press_r: RIGHT -> IDLE, IDLE/LEFT -> RIGHT, HAZARD -> held (ignored).
//   5 timeout: in LEFT/RIGHT, tmr == TIMEOUT_CYCLES-1 -> IDLE, timeout_evt=1.
//  Timer: cleared on every transition into LEFT or RIGHT, including LEFT<->RIGHT.
//   Increments while in LEFT/RIGHT and holds 0 in IDLE/HAZARD.
//   Width $clog2(TIMEOUT_CYCLES). Any press in the expiry cycle wins over timeout.
//  Outputs are registered decodes of the next state, so en_* change in the same
//   cycle as mode. IDLE=00, LEFT en_l=1, RIGHT en_r=1, HAZARD both 1.
// STRUCTURE
//  car_light_pkg.vh (shared include): MODE_IDLE/LEFT/RIGHT/HAZARD 2-bit
//   localparams and CLK_HZ=12000000. The flasher and status logic reuse these.
//  Sub-module btn_debounce(clk, rst, din, level, rise) holds the sync, counter
//   and edge detect, parameter DB_CYCLES. It is instantiated 3x.
//  The top holds the FSM, timeout counter and output registers only.
// TESTING
//  Bench overrides DB_CYCLES=4 and TIMEOUT_CYCLES=50.
//  1 Hold btn_l 10 cycles after reset: mode=1, en_l=1, en_r=0 exactly 8 cycles
//    after the rise. Press btn_l again: mode=0, en=00.
//  2 Bounce btn_r with pulses of 1-3 cycles for 30 cycles, then release: mode
//    stays 0. Then hold 6 cycles: mode=2, en=01.
//  3 LEFT, then press btn_r: mode=2 with the timer cleared. No further presses:
//    exactly 50 cycles later mode=0 and timeout_evt pulses for 1 cycle.
//  4 LEFT, press btn_haz: mode=3, en=11. Press btn_l: still 3. Hold LEFT-style
//    idle 200 cycles: no timeout. Press btn_haz: mode=0.
//  5 btn_l and btn_r rise in the same cycle from IDLE: mode stays 0. Add btn_haz
//    in the same cycle: mode=3.
//  6 Assert rst async mid-debounce while in RIGHT: en=00 and mode=0 immediately.
//    After release, the held btn_r needs a full DB_CYCLES+4 to re-enter RIGHT.

Source files
------------

// File: rtl/car_light_pkg.sv
`default_nettype none
// ============================================================================
// Module      : car_light_pkg
// Description : Shared definitions for the car-light flasher chain.
//               Mode encodings used by the turn-signal FSM, the LED flasher
//               and the status logic, the board clock rate, and a decode
//               helper from mode to the left/right enables.
//               Contents:
//                 MODE_IDLE / MODE_LEFT / MODE_RIGHT / MODE_HAZARD  2-bit modes
//                 CLK_HZ                                            board clock
//                 mode_enables(mode) -> {en_l, en_r}
// Revision    : 1.0  initial release
// ============================================================================
package car_light_pkg;

    localparam logic [1:0] MODE_IDLE   = 2'd0;
    localparam logic [1:0] MODE_LEFT   = 2'd1;
    localparam logic [1:0] MODE_RIGHT  = 2'd2;
    localparam logic [1:0] MODE_HAZARD = 2'd3;

    localparam int CLK_HZ = 12000000;

    // Enable pattern the flasher expects for a given mode, packed {en_l, en_r}.
    // Hazard is signalled to the flasher by both sides being enabled.
    function automatic logic [1:0] mode_enables(input logic [1:0] m);
        logic [1:0] en;
        en = 2'b00;
        case (m)
            MODE_LEFT:   en = 2'b10;
            MODE_RIGHT:  en = 2'b01;
            MODE_HAZARD: en = 2'b11;
            default:     en = 2'b00;
        endcase
        return en;
    endfunction

endpackage
`default_nettype wire

// File: rtl/btn_debounce.sv
`default_nettype none
// ============================================================================
// Module      : btn_debounce
// Description : Conditions one raw, asynchronous push button.
//               Two-flop synchroniser, then a debouncer whose level toggles
//               only after the synchronised input has disagreed with it for
//               DB_CYCLES consecutive cycles; any shorter disagreement reloads
//               the counter. A registered one-cycle pulse marks each debounced
//               0->1 edge. Releases produce no pulse.
//               Ports:
//                 clk    in   system clock
//                 rst    in   asynchronous active-high reset
//                 din    in   raw button, high = pressed
//                 level  out  debounced button level
//                 rise   out  one-cycle pulse on debounced press
// Revision    : 1.0  initial release
// ============================================================================
module btn_debounce #(
    parameter int DB_CYCLES = 240000
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise
);

    // Counter must be able to hold DB_CYCLES-1; one extra value keeps the
    // width non-zero for DB_CYCLES = 1.
    localparam int CW = $clog2(DB_CYCLES + 1);
    localparam logic [CW-1:0] c_cnt_last = CW'(DB_CYCLES - 1);
    localparam logic [CW-1:0] c_cnt_one  = CW'(1);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_level;
    logic          r_level_d;
    logic          r_rise;
    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1   <= 1'b0;
            r_sync2   <= 1'b0;
            r_level   <= 1'b0;
            r_level_d <= 1'b0;
            r_rise    <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_sync1   <= din;
            r_sync2   <= r_sync1;
            r_level_d <= r_level;
            // Edge detect is registered: the pulse appears one cycle after the
            // debounced level has risen.
            r_rise    <= r_level & ~r_level_d;

            if (r_sync2 != r_level) begin
                if (r_cnt == c_cnt_last) begin
                    r_level <= r_sync2;
                    r_cnt   <= '0;
                end else begin
                    r_cnt <= r_cnt + c_cnt_one;
                end
            end else begin
                // Input agrees with the debounced level again: the bounce
                // was too short, start the stability window over.
                r_cnt <= '0;
            end
        end
    end

    assign level = r_level;
    assign rise  = r_rise;

endmodule
`default_nettype wire

// File: rtl/turn_signal_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : turn_signal_ctrl
// Description : Turn-signal mode controller, upstream of the LED flasher.
//               Debounces the left / right / hazard buttons and runs the mode
//               FSM (IDLE, LEFT, RIGHT, HAZARD). Left and right modes cancel
//               themselves after TIMEOUT_CYCLES; hazard mode never times out.
//               Ports:
//                 clk          in   system clock (12 MHz)
//                 rst          in   asynchronous active-high reset
//                 btn_l        in   raw left button
//                 btn_r        in   raw right button
//                 btn_haz      in   raw hazard button
//                 en_l         out  left-side flasher enable, registered
//                 en_r         out  right-side flasher enable, registered
//                 mode         out  current mode (0 IDLE,1 LEFT,2 RIGHT,3 HAZ)
//                 timeout_evt  out  one-cycle pulse on left/right auto-cancel
// Revision    : 1.0  initial release
// ============================================================================
module turn_signal_ctrl
    import car_light_pkg::*;
#(
    parameter int DB_CYCLES      = 240000,
    parameter int TIMEOUT_CYCLES = 360000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_l,
    input  logic       btn_r,
    input  logic       btn_haz,
    output logic       en_l,
    output logic       en_r,
    output logic [1:0] mode,
    output logic       timeout_evt
);

    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] c_tmr_last = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] c_tmr_one  = TW'(1);

    // ------------------------------------------------------------------
    // Button conditioning
    // ------------------------------------------------------------------
    logic w_press_l;
    logic w_press_r;
    logic w_press_haz;

    // Only the press pulses drive the FSM; the debounced levels are
    // deliberately left unconnected.
    btn_debounce #(
        .DB_CYCLES (DB_CYCLES)
    ) u_db_l (
        .clk   (clk),
        .rst   (rst),
        .din   (btn_l),
        .level (),
        .rise  (w_press_l)
    );

    btn_debounce #(
        .DB_CYCLES (DB_CYCLES)
    ) u_db_r (
        .clk   (clk),
        .rst   (rst),
        .din   (btn_r),
        .level (),
        .rise  (w_press_r)
    );

    btn_debounce #(
        .DB_CYCLES (DB_CYCLES)
    ) u_db_haz (
        .clk   (clk),
        .rst   (rst),
        .din   (btn_haz),
        .level (),
        .rise  (w_press_haz)
    );

    // ------------------------------------------------------------------
    // Mode FSM
    // ------------------------------------------------------------------
    logic [1:0]    r_state;
    logic [1:0]    w_state_next;
    logic [TW-1:0] r_tmr;
    logic [TW-1:0] w_tmr_next;
    logic          w_timeout;
    logic          w_turn_now;
    logic          w_turn_next;
    logic          r_en_l;
    logic          r_en_r;
    logic          r_timeout_evt;
    logic [1:0]    w_en_next;

    assign w_turn_now = (r_state == MODE_LEFT) || (r_state == MODE_RIGHT);

    // Events are prioritised hazard > simultaneous L+R > left > right >
    // timeout, so a press landing in the expiry cycle always wins.
    always_comb begin
        w_state_next = r_state;
        w_timeout    = 1'b0;

        if (w_press_haz) begin
            w_state_next = (r_state == MODE_HAZARD) ? MODE_IDLE : MODE_HAZARD;
        end else if (w_press_l && w_press_r) begin
            // Ambiguous request: keep whatever mode is active.
            w_state_next = r_state;
        end else if (w_press_l) begin
            case (r_state)
                MODE_LEFT:  w_state_next = MODE_IDLE;
                MODE_IDLE,
                MODE_RIGHT: w_state_next = MODE_LEFT;
                default:    w_state_next = r_state;
            endcase
        end else if (w_press_r) begin
            case (r_state)
                MODE_RIGHT: w_state_next = MODE_IDLE;
                MODE_IDLE,
                MODE_LEFT:  w_state_next = MODE_RIGHT;
                default:    w_state_next = r_state;
            endcase
        end else if (w_turn_now && (r_tmr == c_tmr_last)) begin
            w_state_next = MODE_IDLE;
            w_timeout    = 1'b1;
        end
    end

    // Timer restarts on every entry into a turn mode (LEFT<->RIGHT included)
    // and sits at zero outside turn modes.
    assign w_turn_next = (w_state_next == MODE_LEFT) || (w_state_next == MODE_RIGHT);

    always_comb begin
        w_tmr_next = '0;
        if (w_turn_next && (w_state_next == r_state)) begin
            w_tmr_next = r_tmr + c_tmr_one;
        end
    end

    assign w_en_next = mode_enables(w_state_next);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= MODE_IDLE;
            r_tmr         <= '0;
            r_en_l        <= 1'b0;
            r_en_r        <= 1'b0;
            r_timeout_evt <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_tmr         <= w_tmr_next;
            // Enables are decoded from the next state so they move in the
            // same cycle as mode.
            r_en_l        <= w_en_next[1];
            r_en_r        <= w_en_next[0];
            r_timeout_evt <= w_timeout;
        end
    end

    assign mode        = r_state;
    assign en_l        = r_en_l;
    assign en_r        = r_en_r;
    assign timeout_evt = r_timeout_evt;

endmodule
`default_nettype wire
